// File: rtl/uart_path_arbiter.sv
// uart_path_arbiter: shares the byte-wide UART TX FIFO write port between the
// APB and AES requesters. Each requester offers 32-bit words on a valid/ready
// handshake; ties are broken round-robin against the last grant. A granted word
// is pushed into the FIFO one byte per cycle, LSB first, stalling on fifo_full.
`timescale 1ns/1ps

package shared_pkg;
  // One-hot controller states; any other pattern is treated as illegal.
  typedef enum logic [2:0] {
    IDLE_UC = 3'b001,
    WAIT_UC = 3'b010,
    PUSH_UC = 3'b100
  } uart_controller_state_e;

  typedef enum logic {
    APB_TO_UART_PATH = 1'b0,
    AES_TO_UART_PATH = 1'b1
  } uart_path_e;
endpackage

module uart_path_arbiter
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NBYTES     = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  apb_valid,
  input  logic [DATA_WIDTH-1:0] apb_data,
  output logic                  apb_ready,
  input  logic                  aes_valid,
  input  logic [DATA_WIDTH-1:0] aes_data,
  output logic                  aes_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [7:0]            fifo_wr_data,
  output logic                  grant_path,
  output logic                  busy
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  uart_controller_state_e   state_q, state_d;
  logic [NBYTES-1:0][7:0]   word_q, word_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  uart_path_e               grant_q, grant_d;
  logic                     busy_q;

  logic apb_win, aes_win;
  logic [7:0] cur_byte;

  // Requester selection: a lone requester always wins, a tie goes to the path
  // that did not own the previous word.
  always_comb begin
    apb_win = 1'b0;
    aes_win = 1'b0;
    if (apb_valid && aes_valid) begin
      if (grant_q == AES_TO_UART_PATH) apb_win = 1'b1;
      else                             aes_win = 1'b1;
    end else if (apb_valid) begin
      apb_win = 1'b1;
    end else if (aes_valid) begin
      aes_win = 1'b1;
    end
  end

  assign cur_byte = word_q[idx_q];

  // Next-state and combinational outputs. Readies are gated by PRESETn so they
  // read low for the whole time reset is asserted.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    grant_d      = grant_q;
    apb_ready    = 1'b0;
    aes_ready    = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = 8'h00;
    case (state_q)
      IDLE_UC: begin
        if (PRESETn && (apb_win || aes_win)) begin
          apb_ready = apb_win;
          aes_ready = aes_win;
          word_d    = apb_win ? apb_data : aes_data;
          grant_d   = apb_win ? APB_TO_UART_PATH : AES_TO_UART_PATH;
          idx_d     = '0;
          state_d   = PUSH_UC;
        end
      end
      PUSH_UC: begin
        fifo_wr_data = cur_byte;
        fifo_wr_en   = !fifo_full;
        if (fifo_full) begin
          state_d = WAIT_UC;
        end else if (idx_q == LAST_IDX) begin
          state_d = IDLE_UC;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      WAIT_UC: begin
        // Hold the pending byte; the push itself happens back in PUSH_UC.
        fifo_wr_data = cur_byte;
        if (!fifo_full) state_d = PUSH_UC;
      end
      default: begin
        state_d = IDLE_UC;
        idx_d   = '0;
      end
    endcase
  end

  // State registers; reset drops any partially sent word.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE_UC;
      word_q  <= '0;
      idx_q   <= '0;
      grant_q <= AES_TO_UART_PATH;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      busy_q  <= (state_d != IDLE_UC);
    end
  end

  assign grant_path = grant_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_path_arbiter.sv
// Bench for uart_path_arbiter: directed scenarios with cycle-exact timelines,
// then randomized traffic checked against a word-queue reference model.
`timescale 1ns/1ps

module tb_uart_path_arbiter;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        apb_valid = 1'b0, aes_valid = 1'b0, fifo_full = 1'b0;
  logic [31:0] apb_data = '0, aes_data = '0;
  logic        apb_ready, aes_ready, fifo_wr_en, grant_path, busy;
  logic [7:0]  fifo_wr_data;

  int errors = 0;
  int checks = 0;

  uart_path_arbiter #(.DATA_WIDTH(32)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .apb_valid(apb_valid), .apb_data(apb_data), .apb_ready(apb_ready),
    .aes_valid(aes_valid), .aes_data(aes_data), .aes_ready(aes_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_path(grant_path), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Move to just after the next rising edge, where inputs are changed.
  task automatic next_cycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic do_reset();
    PRESETn = 1'b0; apb_valid = 1'b0; aes_valid = 1'b0; fifo_full = 1'b0;
    next_cycle();
    next_cycle();
    PRESETn = 1'b1;
  endtask

  task automatic test_reset();
    apb_valid = 1'b1; aes_valid = 1'b1;
    apb_data = $urandom; aes_data = $urandom;
    @(negedge PCLK);
    checks++;
    if ({apb_ready, aes_ready, busy, fifo_wr_en, fifo_wr_data, grant_path} !== {4'b0000, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset: got rdy=%b%b busy=%b en=%b data=%h gp=%b exp rdy=00 busy=0 en=0 data=00 gp=1",
               apb_ready, aes_ready, busy, fifo_wr_en, fifo_wr_data, grant_path);
    end
    next_cycle();
    apb_valid = 1'b0; aes_valid = 1'b0;
    PRESETn = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] w = 32'hA1B2C3D4;
    apb_valid = 1'b1; apb_data = w;
    @(negedge PCLK);
    checks++;
    if ({apb_ready, aes_ready} !== 2'b10) begin
      errors++; $display("FAIL single_accept: got %b%b exp 10", apb_ready, aes_ready);
    end
    next_cycle();
    apb_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge PCLK);
      checks++;
      if ({fifo_wr_en, fifo_wr_data} !== {1'b1, w[8*(c-1) +: 8]}) begin
        errors++; $display("FAIL single_byte c=%0d: got en=%b %h exp en=1 %h", c, fifo_wr_en, fifo_wr_data, w[8*(c-1) +: 8]);
      end
      next_cycle();
    end
    @(negedge PCLK);
    checks++;
    if ({busy, fifo_wr_en, grant_path} !== 3'b000) begin
      errors++; $display("FAIL single_done: got busy=%b en=%b gp=%b exp 0 0 0", busy, fifo_wr_en, grant_path);
    end
    next_cycle();
  endtask

  task automatic test_tie();
    logic [31:0] wa = 32'h11223344;
    logic [31:0] wb = 32'h55667788;
    logic [7:0]  eb;
    do_reset();
    apb_valid = 1'b1; apb_data = wa; aes_valid = 1'b1; aes_data = wb;
    for (int c = 0; c <= 10; c++) begin
      @(negedge PCLK);
      if (c == 0) begin
        checks++;
        if ({apb_ready, aes_ready} !== 2'b10) begin
          errors++; $display("FAIL tie_first: got %b%b exp 10", apb_ready, aes_ready);
        end
      end else if (c == 5) begin
        checks++;
        if ({apb_ready, aes_ready, grant_path, busy} !== 4'b0100) begin
          errors++; $display("FAIL tie_second: got rdy=%b%b gp=%b busy=%b exp rdy=01 gp=0 busy=0", apb_ready, aes_ready, grant_path, busy);
        end
      end else if (c == 10) begin
        checks++;
        if ({busy, grant_path, fifo_wr_en} !== 3'b010) begin
          errors++; $display("FAIL tie_done: got busy=%b gp=%b en=%b exp 0 1 0", busy, grant_path, fifo_wr_en);
        end
      end else begin
        eb = (c < 5) ? wa[8*(c-1) +: 8] : wb[8*(c-6) +: 8];
        checks++;
        if ({fifo_wr_en, fifo_wr_data, apb_ready, aes_ready, grant_path} !== {1'b1, eb, 2'b00, (c > 5)}) begin
          errors++; $display("FAIL tie_byte c=%0d: got en=%b %h rdy=%b%b gp=%b exp en=1 %h rdy=00 gp=%b",
                             c, fifo_wr_en, fifo_wr_data, apb_ready, aes_ready, grant_path, eb, (c > 5));
        end
      end
      next_cycle();
      if (c == 0) apb_valid = 1'b0;
      if (c == 5) aes_valid = 1'b0;
    end
  endtask

  task automatic test_lone();
    logic [31:0] w[3];
    logic [7:0]  got[$];
    logic        er;
    int          k = 0;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    apb_valid = 1'b0;
    for (int c = 0; c <= 15; c++) begin
      aes_valid = (k < 3);
      aes_data  = (k < 3) ? w[k] : 32'h0;
      @(negedge PCLK);
      er = (c % 5 == 0) && (c < 15);
      checks++;
      if ({apb_ready, aes_ready} !== {1'b0, er}) begin
        errors++; $display("FAIL lone_ready c=%0d: got %b%b exp 0%b", c, apb_ready, aes_ready, er);
      end
      if (fifo_wr_en) got.push_back(fifo_wr_data);
      if (aes_valid && aes_ready) k++;
      next_cycle();
    end
    aes_valid = 1'b0;
    checks++;
    if (got.size() != 12) begin
      errors++; $display("FAIL lone_count: got %0d bytes exp 12", got.size());
    end
    for (int i = 0; i < got.size() && i < 12; i++) begin
      checks++;
      if (got[i] !== w[i/4][8*(i%4) +: 8]) begin
        errors++; $display("FAIL lone_byte %0d: got %h exp %h", i, got[i], w[i/4][8*(i%4) +: 8]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w = $urandom;
    logic        een;
    int          bi, pushes = 0;
    apb_valid = 1'b1; apb_data = w;
    @(negedge PCLK);
    checks++;
    if (apb_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept: got %b exp 1", apb_ready);
    end
    next_cycle();
    apb_valid = 1'b0;
    // Full for cycles 2..4 while byte 1 is presented: one WAIT stretch then re-entry.
    for (int c = 1; c <= 9; c++) begin
      fifo_full = (c >= 2 && c <= 4);
      een = (c == 1) || (c >= 6 && c <= 8);
      bi  = (c == 1) ? 0 : (c <= 6) ? 1 : c - 5;
      @(negedge PCLK);
      if (fifo_wr_en) pushes++;
      if (c < 9) begin
        checks++;
        if ({fifo_wr_en, fifo_wr_data, busy} !== {een, w[8*bi +: 8], 1'b1}) begin
          errors++; $display("FAIL bp_cycle c=%0d: got en=%b %h busy=%b exp en=%b %h busy=1",
                             c, fifo_wr_en, fifo_wr_data, busy, een, w[8*bi +: 8]);
        end
      end else begin
        checks++;
        if ({busy, fifo_wr_en} !== 2'b00) begin
          errors++; $display("FAIL bp_done: got busy=%b en=%b exp 0 0", busy, fifo_wr_en);
        end
      end
      next_cycle();
    end
    fifo_full = 1'b0;
    checks++;
    if (pushes != 4) begin
      errors++; $display("FAIL bp_pushes: got %0d exp 4", pushes);
    end
  endtask

  task automatic test_midreset();
    logic [31:0] w  = 32'hDEADBEEF;
    logic [31:0] w2 = $urandom;
    apb_valid = 1'b1; apb_data = w;
    @(negedge PCLK);
    next_cycle();
    apb_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge PCLK);
      checks++;
      if ({fifo_wr_en, fifo_wr_data} !== {1'b1, w[8*(c-1) +: 8]}) begin
        errors++; $display("FAIL mr_byte c=%0d: got en=%b %h exp en=1 %h", c, fifo_wr_en, fifo_wr_data, w[8*(c-1) +: 8]);
      end
      next_cycle();
    end
    apb_valid = 1'b1; apb_data = w2; aes_valid = 1'b1; aes_data = $urandom;
    #1 PRESETn = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({fifo_wr_en, fifo_wr_data, busy, grant_path, apb_ready, aes_ready} !== {1'b0, 8'h00, 1'b0, 1'b1, 2'b00}) begin
        errors++; $display("FAIL mr_reset %0d: got en=%b %h busy=%b gp=%b rdy=%b%b exp en=0 00 busy=0 gp=1 rdy=00",
                           c, fifo_wr_en, fifo_wr_data, busy, grant_path, apb_ready, aes_ready);
      end
      if (c < 2) begin
        @(negedge PCLK);
        if (c == 1) next_cycle();
      end
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({apb_ready, aes_ready} !== 2'b10) begin
      errors++; $display("FAIL mr_first_tie: got %b%b exp 10", apb_ready, aes_ready);
    end
    next_cycle();
    apb_valid = 1'b0; aes_valid = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({grant_path, busy, fifo_wr_en, fifo_wr_data} !== {3'b011, w2[7:0]}) begin
      errors++; $display("FAIL mr_after: got gp=%b busy=%b en=%b %h exp gp=0 busy=1 en=1 %h",
                         grant_path, busy, fifo_wr_en, fifo_wr_data, w2[7:0]);
    end
    repeat (5) next_cycle();
  endtask

  task automatic test_sustained_tie();
    logic [7:0]  exp[$];
    logic [7:0]  got[$];
    logic [31:0] ww;
    logic        last = 1'b1, win = 1'b0;
    int          nacc = 0;
    do_reset();
    apb_valid = 1'b1; aes_valid = 1'b1; apb_data = $urandom; aes_data = $urandom;
    for (int c = 0; c < 20; c++) begin
      @(negedge PCLK);
      if (c % 5 == 0) begin
        win = ~last;
        checks++;
        if ({apb_ready, aes_ready} !== (win ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL st_grant word %0d: got %b%b exp %b", nacc, apb_ready, aes_ready, (win ? 2'b01 : 2'b10));
        end
        checks++;
        if (win !== nacc[0]) begin
          errors++; $display("FAIL st_alternate word %0d: got path %b exp %b", nacc, win, nacc[0]);
        end
        ww = win ? aes_data : apb_data;
        for (int i = 0; i < 4; i++) exp.push_back(ww[8*i +: 8]);
        last = win;
        nacc++;
      end else begin
        checks++;
        if ({apb_ready, aes_ready} !== 2'b00) begin
          errors++; $display("FAIL st_idle_ready c=%0d: got %b%b exp 00", c, apb_ready, aes_ready);
        end
      end
      if (fifo_wr_en) got.push_back(fifo_wr_data);
      next_cycle();
      if (c % 5 == 0) begin
        if (win) aes_data = $urandom;
        else     apb_data = $urandom;
      end
    end
    apb_valid = 1'b0; aes_valid = 1'b0;
    checks++;
    if (got.size() != exp.size()) begin
      errors++; $display("FAIL st_count: got %0d exp %0d", got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("FAIL st_byte %0d: got %h exp %h", i, got[i], exp[i]);
      end
    end
    repeat (2) next_cycle();
  endtask

  // Reference model: a queue of bytes still owed to the FIFO plus the last
  // grant. The block is idle exactly when nothing is owed.
  task automatic test_random();
    logic [7:0] exp[$];
    logic       last = 1'b1;
    logic       ea, eb, acc_a, acc_b;
    logic [31:0] ww;
    int         drain;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (!apb_valid && $urandom_range(0, 2) != 0) begin apb_valid = 1'b1; apb_data = $urandom; end
      if (!aes_valid && $urandom_range(0, 2) != 0) begin aes_valid = 1'b1; aes_data = $urandom; end
      fifo_full = ($urandom_range(0, 3) == 0);
      @(negedge PCLK);
      ea = 1'b0; eb = 1'b0;
      if (exp.size() == 0) begin
        if (apb_valid && aes_valid) begin ea = last; eb = ~last; end
        else begin ea = apb_valid; eb = aes_valid; end
      end
      checks++;
      if ({apb_ready, aes_ready, busy, grant_path} !== {ea, eb, (exp.size() != 0), last}) begin
        errors++; $display("FAIL rnd_ctrl c=%0d: got rdy=%b%b busy=%b gp=%b exp rdy=%b%b busy=%b gp=%b",
                           c, apb_ready, aes_ready, busy, grant_path, ea, eb, (exp.size() != 0), last);
      end
      checks++;
      if (fifo_wr_en && fifo_full) begin
        errors++; $display("FAIL rnd_full c=%0d: got wr_en=1 while full exp wr_en=0", c);
      end
      if (fifo_wr_en) begin
        checks++;
        if (exp.size() == 0) begin
          errors++; $display("FAIL rnd_extra c=%0d: got push %h exp no push", c, fifo_wr_data);
        end else begin
          if (fifo_wr_data !== exp[0]) begin
            errors++; $display("FAIL rnd_byte c=%0d: got %h exp %h", c, fifo_wr_data, exp[0]);
          end
          void'(exp.pop_front());
        end
      end
      acc_a = ea; acc_b = eb;
      if (ea || eb) begin
        ww = ea ? apb_data : aes_data;
        for (int i = 0; i < 4; i++) exp.push_back(ww[8*i +: 8]);
        last = eb;
      end
      next_cycle();
      if (acc_a) apb_valid = 1'b0;
      if (acc_b) aes_valid = 1'b0;
    end
    apb_valid = 1'b0; aes_valid = 1'b0; fifo_full = 1'b0;
    drain = 0;
    while (exp.size() != 0 && drain < 20) begin
      @(negedge PCLK);
      if (fifo_wr_en) begin
        checks++;
        if (fifo_wr_data !== exp[0]) begin
          errors++; $display("FAIL rnd_drain_byte: got %h exp %h", fifo_wr_data, exp[0]);
        end
        void'(exp.pop_front());
      end
      next_cycle();
      drain++;
    end
    checks++;
    if (exp.size() != 0) begin
      errors++; $display("FAIL rnd_drain_timeout: got %0d bytes pending exp 0", exp.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_lone();
    test_backpressure();
    test_midreset();
    test_sustained_tie();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
